cajero_automatico_param: RTL
============================

# cajero_automatico_param

Parametrised ATM transaction controller: the next generation of the Cajero_Automatico block. It accepts a card, collects an N-digit PIN one digit at a time and enforces a configurable attempt limit with warning and lock-out. It then executes one deposit or withdrawal against an internal balance register, charging a commission to foreign cards. It sits between the keypad/card-reader front end and the cash dispenser, and is driven by the existing tester stimulus style.

## Interface
- `N_DIGITOS`, 4: PIN length in BCD/hex digits (≥1).
- `MAX_INTENTOS`, 3: wrong-PIN attempts before lock-out (≥2).
- `MONTO_W`, 32: amount width.
- `BALANCE_W`, 64: balance width (≥ MONTO_W).
- `BALANCE_INIT`, 1000: balance after reset.
- `COMISION_VAL`, 5: fee added to withdrawals by foreign cards.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low (`reset==0` at a rising edge resets).
- `TARJETA_RECIBIDA` in 1: card present (level).
- `TIPO_DE_TARJETA` in 1: 1 = foreign bank card, 0 = own bank; sampled at card acceptance.
- `PIN` in 4*N_DIGITOS: correct PIN; first-entered digit is the MS nibble.
- `DIGITO` in 4: keypad digit; `DIGITO_STB` in 1: digit strobe.
- `TIPO_TRANS` in 1: 0 = deposit, 1 = withdrawal.
- `MONTO` in MONTO_W: amount; `MONTO_STB` in 1: amount strobe.
- `PIN_INCORRECTO`, `ADVERTENCIA`, `BLOQUEO`, `BALANCE_ACTUALIZADO`, `ENTREGAR_DINERO`, `FONDOS_INSUFICIENTES`, `COMISION` out 1 each.
- `BALANCE` out BALANCE_W: current balance.

## Operation
- Strobes are rising-edge detected internally (registered previous value). A strobe held high for many cycles counts once.
- States: IDLE, PIN, CHECK, TRANS, DEPOSITO, RETIRO, FIN, BLOQUEADO.
- **IDLE**
  - `TARJETA_RECIBIDA==1` → PIN.
  - Latches `TIPO_DE_TARJETA` and clears the digit counter.
- **PIN**
  - Each `DIGITO_STB` edge shifts `DIGITO` into the entry register and increments the digit counter.
  - After the N_DIGITOS-th digit → CHECK.
- **CHECK** (1 cycle):
  - **Match** → TRANS. Clears the attempt counter and `ADVERTENCIA`.
  - **Mismatch** → increments the attempt counter and pulses `PIN_INCORRECTO`.
    - If count == MAX_INTENTOS-1, sets `ADVERTENCIA` (level) and goes to PIN.
    - If count == MAX_INTENTOS, goes to BLOQUEADO.
    - Otherwise goes to PIN, with the digit counter cleared.
- **BLOQUEADO**
  - `BLOQUEO` held high; `ADVERTENCIA` held.
  - All strobes and card inputs are ignored. Exit only by reset.
- **TRANS**
  - A `MONTO_STB` edge captures `TIPO_TRANS` and `MONTO`.
  - Goes to DEPOSITO (0) or RETIRO (1).
- **DEPOSITO**
  - `BALANCE <= BALANCE + MONTO`, saturating at 2^BALANCE_W-1.
  - Pulses `BALANCE_ACTUALIZADO`; → FIN.
- **RETIRO**
  - `total = MONTO + (foreign ? COMISION_VAL : 0)`, computed in BALANCE_W+1 bits.
  - **If total ≤ BALANCE:**
    - `BALANCE <= BALANCE - total`.
    - Pulses `ENTREGAR_DINERO` and `BALANCE_ACTUALIZADO`.
    - Pulses `COMISION` if the card is foreign.
  - **Otherwise:** pulses `FONDOS_INSUFICIENTES`; balance is unchanged.
  - → FIN.
- **FIN**: waits for `TARJETA_RECIBIDA==0`, then → IDLE. Exactly one transaction per card insertion.
- **Card removed** (`TARJETA_RECIBIDA==0`) while in PIN or TRANS → IDLE.
  - The partial PIN is discarded.
  - The attempt counter and `ADVERTENCIA` are preserved. Reinsertion does not bypass lock-out; only a correct PIN or reset clears them.
- A strobe arriving in a state that does not consume it is ignored, and its edge is consumed.

## Timing
- **Reset values:** all 1-bit outputs 0, `BALANCE = BALANCE_INIT`, state IDLE, counters 0, edge registers 0.
- All outputs are registered.
- **Pulse outputs** (`PIN_INCORRECTO`, `BALANCE_ACTUALIZADO`, `ENTREGAR_DINERO`, `FONDOS_INSUFICIENTES`, `COMISION`):
  - High for exactly 1 cycle.
  - Visible after the edge that follows the capturing edge.
- **PIN latency:** last digit captured at edge t → CHECK decision at edge t+1 → flags high during cycle t+1..t+2.
- **Transaction latency:** `MONTO_STB` captured at edge t → `BALANCE` and flags updated at edge t+1.
- **Card insertion:** `TARJETA_RECIBIDA` rise sampled at edge t → first digit accepted from edge t+1.
- **Simultaneous events:**
  - Reset dominates everything.
  - Card removal in the same cycle as a `DIGITO_STB`/`MONTO_STB` edge: removal wins and the strobe is discarded.
- `ADVERTENCIA` and `BLOQUEO` are levels: they change only at CHECK or reset.

## Test plan
- **Correct PIN and deposit.** Setup: reset, `PIN=16'hE368`, own card. Digits E,3,6,8 with 1-cycle strobes, then `TIPO_TRANS=0`, `MONTO=15`. Required:
  - `PIN_INCORRECTO` never asserted.
  - `BALANCE` 1000→1015.
  - `BALANCE_ACTUALIZADO` one pulse.
- **Strobe held 8 cycles.** Same flow with `MONTO_STB` held high for 8 cycles. Required: exactly one deposit; `BALANCE`=1015, not more.
- **Lock-out.** Three wrong PINs (0,0,0,0). Required:
  - Three `PIN_INCORRECTO` pulses.
  - `ADVERTENCIA` high after the 2nd.
  - `BLOQUEO` high after the 3rd.
  - A following correct PIN is ignored; only reset (`reset=0` one cycle) clears.
- **Foreign withdrawal.** Foreign card, correct PIN, `TIPO_TRANS=1`, `MONTO=100`. Required:
  - `BALANCE` 1000→895.
  - `ENTREGAR_DINERO`, `COMISION`, `BALANCE_ACTUALIZADO` pulse in the same cycle.
- **Insufficient funds.** Foreign card, `MONTO=996` (total 1001). Required:
  - `FONDOS_INSUFICIENTES` one pulse.
  - `BALANCE` stays 1000.
  - No `ENTREGAR_DINERO`.
- **Removal and reset mid-entry.**
  - One wrong PIN, then remove the card after 2 digits and reinsert. Required: the next wrong PIN raises `ADVERTENCIA` (counter preserved).
  - Assert reset mid-entry. Required: all outputs 0 and `BALANCE`=1000 the next cycle.

Source files
------------

// File: rtl/cajero_automatico_param.sv
// rtl/cajero_automatico_param.sv - parametrised ATM transaction controller (PIN entry, lock-out, deposit/withdrawal)
module cajero_automatico_param #(
  parameter int                   N_DIGITOS    = 4,
  parameter int                   MAX_INTENTOS = 3,
  parameter int                   MONTO_W      = 32,
  parameter int                   BALANCE_W    = 64,
  parameter logic [BALANCE_W-1:0] BALANCE_INIT = BALANCE_W'(1000),
  parameter logic [MONTO_W-1:0]   COMISION_VAL = MONTO_W'(5)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   TARJETA_RECIBIDA,
  input  logic                   TIPO_DE_TARJETA,
  input  logic [4*N_DIGITOS-1:0] PIN,
  input  logic [3:0]             DIGITO,
  input  logic                   DIGITO_STB,
  input  logic                   TIPO_TRANS,
  input  logic [MONTO_W-1:0]     MONTO,
  input  logic                   MONTO_STB,
  output logic                   PIN_INCORRECTO,
  output logic                   ADVERTENCIA,
  output logic                   BLOQUEO,
  output logic                   BALANCE_ACTUALIZADO,
  output logic                   ENTREGAR_DINERO,
  output logic                   FONDOS_INSUFICIENTES,
  output logic                   COMISION,
  output logic [BALANCE_W-1:0]   BALANCE
);

  localparam int PIN_W = 4 * N_DIGITOS;
  localparam int DW    = $clog2(N_DIGITOS + 1);
  localparam int IW    = $clog2(MAX_INTENTOS + 1);
  localparam int SW    = BALANCE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_CHECK,
    S_TRANS,
    S_DEPOSITO,
    S_RETIRO,
    S_FIN,
    S_BLOQUEADO
  } estado_t;

  estado_t            estado;
  logic [PIN_W-1:0]   entrada;
  logic [DW-1:0]      n_dig;
  logic [IW-1:0]      intentos;
  logic               extranjera;
  logic [MONTO_W-1:0] monto_q;
  logic               digito_stb_q;
  logic               monto_stb_q;

  logic               digito_edge;
  logic               monto_edge;
  logic [IW-1:0]      intentos_inc;
  logic [PIN_W-1:0]   digito_ext;
  logic [SW-1:0]      saldo_ext;
  logic [SW-1:0]      suma;
  logic [SW-1:0]      total;

  // A strobe counts once per rising edge, however long it is held.
  assign digito_edge  = DIGITO_STB & ~digito_stb_q;
  assign monto_edge   = MONTO_STB & ~monto_stb_q;
  assign intentos_inc = intentos + 1'b1;
  assign digito_ext   = PIN_W'(DIGITO);

  // Arithmetic carries one extra bit so deposit overflow and withdrawal shortfall are both visible.
  assign saldo_ext = {1'b0, BALANCE};
  assign suma      = saldo_ext + SW'(monto_q);
  assign total     = SW'(monto_q) + (extranjera ? SW'(COMISION_VAL) : SW'(0));

  // Previous-value registers for strobe edge detection, updated in every state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digito_stb_q <= 1'b0;
      monto_stb_q  <= 1'b0;
    end else begin
      digito_stb_q <= DIGITO_STB;
      monto_stb_q  <= MONTO_STB;
    end
  end

  // Transaction state machine with registered pulse and level outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado               <= S_IDLE;
      entrada              <= '0;
      n_dig                <= '0;
      intentos             <= '0;
      extranjera           <= 1'b0;
      monto_q              <= '0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      COMISION             <= 1'b0;
      BALANCE              <= BALANCE_INIT;
    end else begin
      PIN_INCORRECTO       <= 1'b0;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      COMISION             <= 1'b0;

      case (estado)
        S_IDLE: begin
          n_dig <= '0;
          if (TARJETA_RECIBIDA) begin
            extranjera <= TIPO_DE_TARJETA;
            estado     <= S_PIN;
          end
        end

        S_PIN: begin
          // Removal wins over a simultaneous digit; attempt count and warning survive.
          if (!TARJETA_RECIBIDA) begin
            n_dig  <= '0;
            estado <= S_IDLE;
          end else if (digito_edge) begin
            entrada <= (entrada << 4) | digito_ext;
            n_dig   <= n_dig + 1'b1;
            if (n_dig == DW'(N_DIGITOS - 1)) begin
              estado <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          n_dig <= '0;
          if (entrada == PIN) begin
            intentos    <= '0;
            ADVERTENCIA <= 1'b0;
            estado      <= S_TRANS;
          end else begin
            intentos       <= intentos_inc;
            PIN_INCORRECTO <= 1'b1;
            if (intentos_inc >= IW'(MAX_INTENTOS)) begin
              BLOQUEO <= 1'b1;
              estado  <= S_BLOQUEADO;
            end else begin
              if (intentos_inc == IW'(MAX_INTENTOS - 1)) begin
                ADVERTENCIA <= 1'b1;
              end
              estado <= S_PIN;
            end
          end
        end

        S_TRANS: begin
          if (!TARJETA_RECIBIDA) begin
            estado <= S_IDLE;
          end else if (monto_edge) begin
            monto_q <= MONTO;
            estado  <= TIPO_TRANS ? S_RETIRO : S_DEPOSITO;
          end
        end

        S_DEPOSITO: begin
          BALANCE             <= suma[SW-1] ? {BALANCE_W{1'b1}} : suma[BALANCE_W-1:0];
          BALANCE_ACTUALIZADO <= 1'b1;
          estado              <= S_FIN;
        end

        S_RETIRO: begin
          if (total <= saldo_ext) begin
            BALANCE             <= BALANCE - total[BALANCE_W-1:0];
            ENTREGAR_DINERO     <= 1'b1;
            BALANCE_ACTUALIZADO <= 1'b1;
            COMISION            <= extranjera;
          end else begin
            FONDOS_INSUFICIENTES <= 1'b1;
          end
          estado <= S_FIN;
        end

        S_FIN: begin
          if (!TARJETA_RECIBIDA) begin
            estado <= S_IDLE;
          end
        end

        S_BLOQUEADO: begin
          estado <= S_BLOQUEADO;
        end

        default: begin
          estado <= S_IDLE;
        end
      endcase
    end
  end

endmodule
